// File: rtl/inst_cache_if.sv
// Fetch port and refill port of the instruction cache, bundled as one interface.
// The cache takes the slave view; the CPU fetch stage plus instruction memory take the master view.
interface inst_cache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  rom_ce;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] inst_data;
    logic                  inst_valid;
    logic                  flush;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  rom_ce, rom_addr, flush, mem_ack, mem_rdata,
        output inst_data, inst_valid, mem_req, mem_addr
    );

    modport master (
        output rom_ce, rom_addr, flush, mem_ack, mem_rdata,
        input  inst_data, inst_valid, mem_req, mem_addr
    );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, whole-line refill
// through a req/ack word port, and a flush that invalidates every line.
module inst_cache #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input logic         clk,
    input logic         rst,
    inst_cache_if.slave bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS - 2;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        FILL_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES*WORDS];
    logic [LINES-1:0]      valid;

    logic [TAG_BITS-1:0]    fill_tag;
    logic [INDEX_BITS-1:0]  fill_idx;
    logic [OFFSET_BITS-1:0] cnt;
    logic                   pending_flush;

    logic [TAG_BITS-1:0]    fetch_tag;
    logic [INDEX_BITS-1:0]  fetch_idx;
    logic [OFFSET_BITS-1:0] fetch_word;
    logic                   tag_hit;
    logic                   lookup_hit;
    logic                   start_refill;
    logic                   word_ack;
    logic                   last_ack;
    logic                   unused_byte_bits;

    assign fetch_tag        = bus.rom_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign fetch_idx        = bus.rom_addr[OFFSET_BITS+2 +: INDEX_BITS];
    assign fetch_word       = bus.rom_addr[2 +: OFFSET_BITS];
    assign unused_byte_bits = ^bus.rom_addr[1:0];

    assign tag_hit = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);

    // Lookups are served only in IDLE, so the line arrays never need a second read port
    assign lookup_hit   = (state == IDLE) && !rst && bus.rom_ce && !bus.flush && tag_hit;
    assign start_refill = (state == IDLE) && bus.rom_ce && !bus.flush && !tag_hit;
    assign word_ack     = (state == REFILL) && bus.mem_ack;
    assign last_ack     = word_ack && (cnt == OFFSET_BITS'(WORDS - 1));

    assign bus.inst_valid = lookup_hit;
    assign bus.inst_data  = lookup_hit ? data_mem[{fetch_idx, fetch_word}] : '0;
    assign bus.mem_req    = (state == REFILL);
    assign bus.mem_addr   = (state == REFILL) ? {fill_tag, fill_idx, cnt, 2'b00} : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (start_refill) state_next = REFILL;
            REFILL:    if (last_ack)     state_next = FILL_DONE;
            FILL_DONE: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Line base is captured at the miss; later rom_addr changes do not disturb the refill
    always_ff @(posedge clk) begin
        if (start_refill) begin
            fill_tag <= fetch_tag;
            fill_idx <= fetch_idx;
            cnt      <= '0;
        end else if (word_ack) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (word_ack && !rst) begin
            data_mem[{fill_idx, cnt}] <= bus.mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if ((state == FILL_DONE) && !rst) begin
            tag_mem[fill_idx] <= fill_tag;
        end
    end

    // A flush seen while a line is in flight leaves that line invalid once it lands
    always_ff @(posedge clk) begin
        if (rst) begin
            valid         <= '0;
            pending_flush <= 1'b0;
        end else begin
            if (bus.flush) begin
                valid <= '0;
            end else if ((state == FILL_DONE) && !pending_flush) begin
                valid[fill_idx] <= 1'b1;
            end

            if (state == FILL_DONE) begin
                pending_flush <= 1'b0;
            end else if ((state == REFILL) && bus.flush) begin
                pending_flush <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed cold-miss/hit/conflict/flush/reset scenarios,
// then randomized fetch traffic, all checked every cycle against a line-level cache model.
`timescale 1ns/1ps
module tb_inst_cache;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    inst_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    inst_cache #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INDEX_BITS (4),
        .OFFSET_BITS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Memory content is a pure function of the word address
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'h0000_A5A5;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Memory responder: ack arrives on the ack_lat-th cycle a word has been requested
    int wait_cnt  = 0;
    int ack_lat   = 2;
    bit rand_lat  = 1'b0;
    bit stray_en  = 1'b0;

    always @(posedge clk) begin
        #1;
        bus.mem_ack = 1'b0;
        if (bus.mem_req === 1'b1) begin
            wait_cnt++;
            if (wait_cnt >= ack_lat) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_fn(bus.mem_addr);
                wait_cnt      = 0;
                if (rand_lat) ack_lat = $urandom_range(1, 3);
            end
        end else begin
            wait_cnt = 0;
            if (stray_en && ($urandom_range(0, 9) == 0)) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = $urandom;
            end
        end
    end

    logic [31:0] acc_q[$];

    always @(posedge clk) begin
        if (!rst && bus.mem_req === 1'b1 && bus.mem_ack === 1'b1) acc_q.push_back(bus.mem_addr);
    end

    // Cache model: per-line valid/tag plus one in-flight refill record
    bit          model_on = 1'b0;
    bit          m_valid[16];
    logic [23:0] m_tag[16];
    bit          r_active, r_done, r_doomed;
    int          r_words;
    logic [31:0] r_base;
    logic [3:0]  m_idx;
    bit          m_hit;

    always @(posedge clk) begin
        m_idx = bus.rom_addr[7:4];
        m_hit = m_valid[m_idx] && (m_tag[m_idx] == bus.rom_addr[31:8]);
        if (rst) begin
            model_on = 1'b1;
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            r_active = 1'b0;
            r_done   = 1'b0;
        end else if (model_on) begin
            if (r_done) begin
                m_tag[r_base[7:4]] = r_base[31:8];
                if (bus.flush) foreach (m_valid[i]) m_valid[i] = 1'b0;
                else if (!r_doomed) m_valid[r_base[7:4]] = 1'b1;
                r_done = 1'b0;
            end else if (r_active) begin
                if (bus.flush) begin
                    foreach (m_valid[i]) m_valid[i] = 1'b0;
                    r_doomed = 1'b1;
                end
                if (bus.mem_ack) begin
                    r_words++;
                    if (r_words == 4) begin
                        r_active = 1'b0;
                        r_done   = 1'b1;
                    end
                end
            end else if (bus.flush) begin
                foreach (m_valid[i]) m_valid[i] = 1'b0;
            end else if (bus.rom_ce && !m_hit) begin
                r_active = 1'b1;
                r_base   = {bus.rom_addr[31:4], 4'h0};
                r_words  = 0;
                r_doomed = 1'b0;
            end
        end
    end

    logic [3:0] c_idx;
    bit         exp_hit;

    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("mem_req", bus.mem_req, r_active);
            if (r_active) checkOutput("mem_addr", bus.mem_addr, r_base + 32'(4 * r_words));
            if (!rst) begin
                c_idx   = bus.rom_addr[7:4];
                exp_hit = !r_active && !r_done && bus.rom_ce && !bus.flush &&
                          m_valid[c_idx] && (m_tag[c_idx] == bus.rom_addr[31:8]);
                checkOutput("inst_valid", bus.inst_valid, exp_hit);
                checkOutput("inst_data", bus.inst_data,
                            exp_hit ? mem_fn({bus.rom_addr[31:2], 2'b00}) : 32'h0);
            end
        end
    end

    task automatic applyStimulus(input bit ce, input logic [31:0] addr, input bit fl);
        @(posedge clk);
        #1;
        bus.rom_ce   = ce;
        bus.rom_addr = addr;
        bus.flush    = fl;
    endtask

    task automatic waitHit(input int max_cycles, output int cycles);
        cycles = 0;
        forever begin
            @(negedge clk);
            if (bus.inst_valid === 1'b1) return;
            if (cycles >= max_cycles) begin
                checkOutput("hit_timeout", bus.inst_valid, 1);
                return;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic waitAcks(input int n, input int max_cycles);
        for (int c = 0; c < max_cycles; c++) begin
            @(posedge clk);
            #1;
            if (acc_q.size() >= n) return;
        end
        checkOutput("ack_timeout", 32'(acc_q.size()), 32'(n));
    endtask

    task automatic checkLine(input string name, input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            if (acc_q.size() == 0) begin
                checkOutput({name, "_words"}, 32'(i), 4);
                return;
            end
            checkOutput({name, "_addr"}, acc_q.pop_front(), base + 32'(4 * i));
        end
    endtask

    int          cyc;
    logic [31:0] raddr;

    initial begin
        rst           = 1'b1;
        bus.rom_ce    = 1'b0;
        bus.rom_addr  = '0;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        checkOutput("rst_mem_req", bus.mem_req, 0);
        checkOutput("rst_mem_addr", bus.mem_addr, 0);
        checkOutput("rst_inst_valid", bus.inst_valid, 0);
        checkOutput("rst_inst_data", bus.inst_data, 0);

        $display("[TB] T1 cold miss");
        acc_q.delete();
        applyStimulus(1, 32'h40, 0);
        waitHit(100, cyc);
        checkOutput("t1_latency", 32'(cyc), 10);
        checkOutput("t1_data", bus.inst_data, 32'hA5E5);
        checkLine("t1", 32'h40);

        $display("[TB] T2 hit");
        applyStimulus(1, 32'h48, 0);
        @(negedge clk);
        checkOutput("t2_valid", bus.inst_valid, 1);
        checkOutput("t2_data", bus.inst_data, 32'hA5ED);
        checkOutput("t2_req", bus.mem_req, 0);

        $display("[TB] T3 conflict");
        applyStimulus(1, 32'h440, 0);
        waitHit(100, cyc);
        checkOutput("t3_data", bus.inst_data, 32'hA1E5);
        checkLine("t3", 32'h440);
        applyStimulus(1, 32'h40, 0);
        @(negedge clk);
        checkOutput("t3_evicted", bus.inst_valid, 0);
        waitHit(100, cyc);
        checkOutput("t3_back_data", bus.inst_data, 32'hA5E5);
        checkLine("t3_back", 32'h40);

        $display("[TB] T4 flush in idle");
        applyStimulus(1, 32'h44, 1);
        @(negedge clk);
        checkOutput("t4_flush_cycle", bus.inst_valid, 0);
        applyStimulus(1, 32'h44, 0);
        @(negedge clk);
        checkOutput("t4_miss", bus.inst_valid, 0);
        checkOutput("t4_no_req_yet", bus.mem_req, 0);
        waitHit(100, cyc);
        checkOutput("t4_data", bus.inst_data, 32'hA5E1);
        checkLine("t4", 32'h40);

        $display("[TB] T5 flush mid-refill");
        acc_q.delete();
        applyStimulus(1, 32'h80, 0);
        waitAcks(1, 50);
        applyStimulus(1, 32'h80, 1);
        applyStimulus(1, 32'h80, 0);
        waitHit(200, cyc);
        checkOutput("t5_words", 32'(acc_q.size()), 8);
        checkOutput("t5_data", bus.inst_data, 32'hA525);
        checkLine("t5_first", 32'h80);
        checkLine("t5_second", 32'h80);

        $display("[TB] T6 reset mid-refill");
        acc_q.delete();
        applyStimulus(1, 32'h100, 0);
        waitAcks(1, 50);
        rst        = 1'b1;
        bus.rom_ce = 1'b0;
        @(negedge clk);
        checkOutput("t6_req_in_rst", bus.mem_req, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t6_req_dropped", bus.mem_req, 0);
        checkOutput("t6_valid", bus.inst_valid, 0);
        repeat (4) begin
            @(negedge clk);
            checkOutput("t6_idle_req", bus.mem_req, 0);
        end
        acc_q.delete();
        applyStimulus(1, 32'h100, 0);
        @(negedge clk);
        checkOutput("t6_partial_invalid", bus.inst_valid, 0);
        waitHit(100, cyc);
        checkOutput("t6_data", bus.inst_data, 32'hA4A5);
        checkLine("t6", 32'h100);

        $display("[TB] random traffic");
        rand_lat = 1'b1;
        stray_en = 1'b1;
        raddr    = 32'h0;
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 3))
                0:       raddr = (32'($urandom_range(0, 2)) << 8) | ($urandom & 32'hFF);
                1:       raddr = raddr + 32'h4;
                default: raddr = raddr;
            endcase
            applyStimulus($urandom_range(0, 9) != 0, raddr, $urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 299) == 0);
        end
        applyStimulus(0, 32'h0, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
